scanout_ctrl: RTL and testbench
===============================

// Module: scanout_ctrl
// PURPOSE
//  Display scanout stage that sits directly downstream of the frame buffer (Buf0).
//  Generates raster timing, drives the buffer read port (RE0/Addr0) in raster order,
//  and re-registers the returned R/G/B with hsync/vsync/de aligned to the pixel data.
//  Exports vblank so the upstream writer writes only while no read is pending.
// PARAMETERS
//  H_ACTIVE   100  visible pixels per line
//  H_FP       4    horizontal front porch, in clocks
//  H_SYNC     8    hsync width, in clocks
//  H_BP       8    horizontal back porch, in clocks (H_TOTAL = 120)
//  V_ACTIVE   100  visible lines per frame (H_ACTIVE*V_ACTIVE <= 10000)
//  V_FP       2    vertical front porch, in lines
//  V_SYNC     2    vsync width, in lines
//  V_BP       4    vertical back porch, in lines (V_TOTAL = 108)
//  SYNC_POL   0    level of hsync/vsync while in their sync window (0 = active-low)
// PORTS
//  clk       in   1   single clock; all logic acts on its rising edge
//  reset     in   1   synchronous reset, active-low; sampled on the clk rising edge
//  en        in   1   scanout enable
//  wr_busy   in   1   upstream write strobe (the buffer's WE0), used for collision detect
//  R_in      in   8   R0 from the buffer
//  G_in      in   8   G0 from the buffer
//  B_in      in   8   B0 from the buffer
//  RE0       out  1   buffer read enable
//  Addr0     out  20  buffer read address
//  pix_r     out  8   output pixel red
//  pix_g     out  8   output pixel green
//  pix_b     out  8   output pixel blue
//  hsync     out  1   horizontal sync
//  vsync     out  1   vertical sync
//  de        out  1   data enable: high only for visible pixels
//  vblank    out  1   high while v_cnt >= V_ACTIVE, or while in IDLE (write window)
//  frame_done out 1   1-cycle pulse on the last counter position of a frame
//  collision out  1   sticky: wr_busy was high in a cycle where RE0 was high
// BEHAVIOUR
//  Reset (reset==0): state=IDLE; h_cnt=v_cnt=Addr0=0; RE0=0; de=0; pix_*=0;
//   hsync=vsync=~SYNC_POL; vblank=1; frame_done=0; collision=0.
//  FSM IDLE->RUN: en==1 in IDLE. The first RUN cycle is counter position (0,0).
//  FSM RUN->IDLE: only at the frame wrap (h=H_TOTAL-1, v=V_TOTAL-1) if en==0 then.
//   Dropping en mid-frame never truncates the frame.
//  Counters: h_cnt runs 0..H_TOTAL-1. At the wrap h_cnt goes to 0 and v_cnt increments.
//   v_cnt runs 0..V_TOTAL-1, then wraps to 0.
//  Read port: RE0 is registered; RE0=1 when h<H_ACTIVE and v<V_ACTIVE.
//   Addr0 is an incrementing 20-bit counter, not a multiplier: it advances after each
//   active pixel and is cleared to 0 at the frame wrap. Visible pixel (h,v) reads v*H_ACTIVE+h.
//   Addr0 holds its last value while RE0=0.
//  Latency, counter position to output = 2 clocks:
//   - edge k: RE0 and Addr0 are registered.
//   - edge k+1: the buffer produces R/G/B.
//   - edge k+2: pix_*, de, hsync and vsync update together.
//   The sync and de terms pass through two delay stages to stay aligned with pixel data.
//  Pixels: pix_* = {R_in,G_in,B_in} when the delayed de==1, otherwise 0 (blanked).
//  Sync windows: hsync=SYNC_POL for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//   vsync=SYNC_POL for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. Otherwise ~SYNC_POL.
//  vblank: undelayed (counter-aligned) and registered. RE0 is 0 for the whole time vblank=1.
//  frame_done: undelayed, asserted at (H_TOTAL-1, V_TOTAL-1).
//  collision: set when wr_busy&&RE0, since the buffer drops such reads.
//   Cleared only by reset.
//  IDLE: RE0=0; syncs idle at ~SYNC_POL; pix_*=0; the pipeline flushes 2 clocks after entry.
//  Reset in mid-frame: all state returns to reset values on the next edge;
//   the next frame starts at (0,0), Addr0=0.
// TESTING
//  T1 reset: hold reset=0 for 3 clk with en=1 -> RE0=0, de=0, pix_*=0, hsync=vsync=1, vblank=1.
//  T2 first frame: release reset, en=1 -> cycle 1 RE0=1, Addr0=0; Addr0=99 at h=99;
//     line 1 starts at Addr0=100; last read is Addr0=9999; then RE0=0 for 8 lines.
//  T3 alignment: buffer model (1-clk latency) holding data=addr -> de rises 2 clk after RE0;
//     the first pix = {R=0,G=0,B=0}; pixel 257 (B,G,R = 0x00,0x01,0x01) appears exactly 2 clk
//     after Addr0=257.
//  T4 timing: count clocks -> hsync low for 8 clk starting at h=104; each line is 120 clk;
//     vsync low for lines 102-103; each frame is 12960 clk; frame_done pulses once per frame.
//  T5 enable: drop en at v=50 -> the frame completes, frame_done pulses, the FSM goes IDLE,
//     vblank=1, RE0 stays 0; raise en -> the next cycle is (0,0) with Addr0=0.
//  T6 collision: wr_busy=1 at one active pixel -> collision=1 and stays 1 after wr_busy=0;
//     the same pulse during vblank leaves collision=0; reset clears it.

Source files
------------

// File: rtl/scanout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scanout_ctrl
// Description : Display scanout stage behind the frame buffer (Buf0).
//               Generates raster timing and drives the buffer read port
//               (RE0/Addr0) in raster order. It re-registers the returned
//               R/G/B with hsync/vsync/de delayed to line up with the pixels.
//               It exports vblank so the upstream writer only writes while
//               no read is pending.
// Ports       : clk        - single clock, rising edge
//               reset      - synchronous reset, active low
//               en         - scanout enable (checked at frame boundaries)
//               wr_busy    - upstream write strobe (buffer WE0)
//               R_in/G_in/B_in - buffer read data (1-clk latency)
//               RE0/Addr0  - buffer read enable / address
//               pix_r/g/b  - output pixel, blanked outside de
//               hsync/vsync/de - timing outputs, aligned with pix_*
//               vblank     - counter-aligned vertical blank / idle window
//               frame_done - pulse on the last counter position of a frame
//               collision  - sticky: a write hit a cycle with RE0 high
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_ctrl #(
   parameter int H_ACTIVE = 100,
   parameter int H_FP     = 4,
   parameter int H_SYNC   = 8,
   parameter int H_BP     = 8,
   parameter int V_ACTIVE = 100,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 4,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        wr_busy,
   input  logic [7:0]  R_in,
   input  logic [7:0]  G_in,
   input  logic [7:0]  B_in,
   output logic        RE0,
   output logic [19:0] Addr0,
   output logic [7:0]  pix_r,
   output logic [7:0]  pix_g,
   output logic [7:0]  pix_b,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        vblank,
   output logic        frame_done,
   output logic        collision
);

   localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int C_HW      = $clog2(C_H_TOTAL);
   localparam int C_VW      = $clog2(C_V_TOTAL);

   localparam logic [C_HW-1:0] C_H_LAST     = C_HW'(C_H_TOTAL - 1);
   localparam logic [C_HW-1:0] C_H_ACT      = C_HW'(H_ACTIVE);
   localparam logic [C_HW-1:0] C_HS_START   = C_HW'(H_ACTIVE + H_FP);
   localparam logic [C_HW-1:0] C_HS_END     = C_HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [C_VW-1:0] C_V_LAST     = C_VW'(C_V_TOTAL - 1);
   localparam logic [C_VW-1:0] C_V_ACT      = C_VW'(V_ACTIVE);
   localparam logic [C_VW-1:0] C_VS_START   = C_VW'(V_ACTIVE + V_FP);
   localparam logic [C_VW-1:0] C_VS_END     = C_VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic            C_SYNC_IDLE  = ~SYNC_POL;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [C_HW-1:0]   r_h;
   logic [C_VW-1:0]   r_v;
   logic [C_HW-1:0]   w_h_nxt;
   logic [C_VW-1:0]   w_v_nxt;
   logic              w_wrap;
   logic              w_run_nxt;
   logic              w_re_nxt;
   logic              w_hs_nxt;
   logic              w_vs_nxt;
   logic              w_vblank_nxt;
   logic              w_fd_nxt;
   logic [19:0]       r_ptr;
   logic [19:0]       w_ptr_base;

   // Pipeline stages: stage 0 is counter-aligned (same edge as RE0),
   // stage 1 lines up with the buffer returning data.
   logic              r_hs0;
   logic              r_vs0;
   logic              r_de1;
   logic              r_hs1;
   logic              r_vs1;

   // ------------------------------------------------------------------
   // Next counter position. Everything registered below is derived from
   // the next position so that RE0/vblank/frame_done change on the same
   // edge as the counters themselves.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      w_wrap      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en) begin
               w_state_nxt = ST_RUN;
               w_h_nxt     = '0;
               w_v_nxt     = '0;
            end
         end
         ST_RUN: begin
            if (r_h == C_H_LAST) begin
               w_h_nxt = '0;
               if (r_v == C_V_LAST) begin
                  // en is only honoured here so a frame is never truncated.
                  w_v_nxt = '0;
                  w_wrap  = 1'b1;
                  if (!en) begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_v_nxt = r_v + 1'b1;
               end
            end else begin
               w_h_nxt = r_h + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
         end
      endcase
   end

   assign w_run_nxt    = (w_state_nxt == ST_RUN);
   assign w_re_nxt     = w_run_nxt && (w_h_nxt < C_H_ACT) && (w_v_nxt < C_V_ACT);
   assign w_hs_nxt     = (w_run_nxt && (w_h_nxt >= C_HS_START) && (w_h_nxt < C_HS_END))
                         ? SYNC_POL : C_SYNC_IDLE;
   assign w_vs_nxt     = (w_run_nxt && (w_v_nxt >= C_VS_START) && (w_v_nxt < C_VS_END))
                         ? SYNC_POL : C_SYNC_IDLE;
   assign w_vblank_nxt = !w_run_nxt || (w_v_nxt >= C_V_ACT);
   assign w_fd_nxt     = w_run_nxt && (w_h_nxt == C_H_LAST) && (w_v_nxt == C_V_LAST);

   // Read pointer restarts at the frame wrap; when the next frame starts
   // immediately, its first pixel must use address 0.
   assign w_ptr_base   = w_wrap ? '0 : r_ptr;

   // ------------------------------------------------------------------
   // State, counters, read port and counter-aligned flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_h        <= '0;
         r_v        <= '0;
         r_ptr      <= '0;
         RE0        <= 1'b0;
         Addr0      <= '0;
         r_hs0      <= C_SYNC_IDLE;
         r_vs0      <= C_SYNC_IDLE;
         vblank     <= 1'b1;
         frame_done <= 1'b0;
         collision  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_h        <= w_h_nxt;
         r_v        <= w_v_nxt;
         RE0        <= w_re_nxt;
         r_hs0      <= w_hs_nxt;
         r_vs0      <= w_vs_nxt;
         vblank     <= w_vblank_nxt;
         frame_done <= w_fd_nxt;
         // Address only moves on reads, so it holds through blanking.
         if (w_re_nxt) begin
            Addr0 <= w_ptr_base;
            r_ptr <= w_ptr_base + 20'd1;
         end else if (w_wrap) begin
            Addr0 <= '0;
            r_ptr <= '0;
         end
         // The buffer drops a read that coincides with a write.
         if (wr_busy && RE0) begin
            collision <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output pipeline: two stages behind the counters to meet the data
   // returned by the buffer one clock after RE0.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_de1 <= 1'b0;
         r_hs1 <= C_SYNC_IDLE;
         r_vs1 <= C_SYNC_IDLE;
         de    <= 1'b0;
         hsync <= C_SYNC_IDLE;
         vsync <= C_SYNC_IDLE;
         pix_r <= '0;
         pix_g <= '0;
         pix_b <= '0;
      end else begin
         r_de1 <= RE0;
         r_hs1 <= r_hs0;
         r_vs1 <= r_vs0;
         de    <= r_de1;
         hsync <= r_hs1;
         vsync <= r_vs1;
         pix_r <= r_de1 ? R_in : 8'd0;
         pix_g <= r_de1 ? G_in : 8'd0;
         pix_b <= r_de1 ? B_in : 8'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scanout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanout_ctrl
// Description : Self-checking bench for scanout_ctrl. A reference raster
//               model runs alongside the DUT and queues the expected output
//               for each counter position; entries are popped two clocks
//               later when the pipelined outputs appear. Scenario tasks add
//               targeted checks on top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scanout_ctrl;

   logic        clk;
   logic        reset;
   logic        en;
   logic        wr_busy;
   logic [7:0]  R_in;
   logic [7:0]  G_in;
   logic [7:0]  B_in;
   logic        RE0;
   logic [19:0] Addr0;
   logic [7:0]  pix_r;
   logic [7:0]  pix_g;
   logic [7:0]  pix_b;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic        vblank;
   logic        frame_done;
   logic        collision;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   scanout_ctrl u_dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .wr_busy    (wr_busy),
      .R_in       (R_in),
      .G_in       (G_in),
      .B_in       (B_in),
      .RE0        (RE0),
      .Addr0      (Addr0),
      .pix_r      (pix_r),
      .pix_g      (pix_g),
      .pix_b      (pix_b),
      .hsync      (hsync),
      .vsync      (vsync),
      .de         (de),
      .vblank     (vblank),
      .frame_done (frame_done),
      .collision  (collision)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Buffer model: 1-clock read latency, data = address with
   // R = addr[7:0], G = addr[15:8], B = addr[19:16].
   initial begin
      R_in = 8'd0;
      G_in = 8'd0;
      B_in = 8'd0;
   end
   always @(posedge clk) begin
      if (RE0) begin
         R_in <= Addr0[7:0];
         G_in <= Addr0[15:8];
         B_in <= {4'd0, Addr0[19:16]};
      end
   end

   function automatic logic [23:0] pix_of(input int a);
      logic [19:0] av;
      av = 20'(a);
      return {av[7:0], av[15:8], {4'd0, av[19:16]}};
   endfunction

   // ------------------------------------------------------------------
   // Reference raster model (position = state after the latest edge)
   // ------------------------------------------------------------------
   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic [23:0] pix;
   } exp_t;

   exp_t q_exp[$];
   exp_t c_idle;
   exp_t e_cur;
   exp_t e_old;
   bit   m_run  = 1'b0;
   int   m_h    = 0;
   int   m_v    = 0;
   int   m_addr = 0;
   bit   m_coll = 1'b0;
   logic m_re;

   initial c_idle = {1'b0, 1'b1, 1'b1, 24'h0};

   always @(posedge clk) begin
      if (!reset) begin
         m_run  = 1'b0;
         m_h    = 0;
         m_v    = 0;
         m_addr = 0;
         m_coll = 1'b0;
         q_exp.delete();
         q_exp.push_back(c_idle);
         q_exp.push_back(c_idle);
      end else begin
         if (wr_busy && m_run && m_h < 100 && m_v < 100) m_coll = 1'b1;
         if (!m_run) begin
            if (en) begin
               m_run = 1'b1;
               m_h   = 0;
               m_v   = 0;
            end
         end else if (m_h == 119 && m_v == 107) begin
            m_h    = 0;
            m_v    = 0;
            m_addr = 0;
            m_run  = en;
         end else if (m_h == 119) begin
            m_h = 0;
            m_v = m_v + 1;
         end else begin
            m_h = m_h + 1;
         end
         if (m_run && m_h < 100 && m_v < 100) m_addr = m_v * 100 + m_h;
      end
   end

   // Scoreboard: push expectation for current position, pop the one from
   // two positions earlier and compare against the pipelined outputs.
   always @(negedge clk) begin
      if (chk_en) begin
         m_re = m_run && m_h < 100 && m_v < 100;
         n_checks++;
         if (RE0 !== m_re) begin
            n_fail++;
            $display("FAIL sb_re0 pos=(%0d,%0d) got=%b exp=%b", m_h, m_v, RE0, m_re);
         end
         n_checks++;
         if (Addr0 !== 20'(m_addr)) begin
            n_fail++;
            $display("FAIL sb_addr0 pos=(%0d,%0d) got=%0d exp=%0d", m_h, m_v, Addr0, m_addr);
         end
         n_checks++;
         if (vblank !== (!m_run || m_v >= 100)) begin
            n_fail++;
            $display("FAIL sb_vblank pos=(%0d,%0d) got=%b", m_h, m_v, vblank);
         end
         n_checks++;
         if (frame_done !== (m_run && m_h == 119 && m_v == 107)) begin
            n_fail++;
            $display("FAIL sb_frame_done pos=(%0d,%0d) got=%b", m_h, m_v, frame_done);
         end
         n_checks++;
         if (collision !== m_coll) begin
            n_fail++;
            $display("FAIL sb_collision got=%b exp=%b", collision, m_coll);
         end
         e_cur.de  = m_re;
         e_cur.hs  = !(m_run && m_h >= 104 && m_h < 112);
         e_cur.vs  = !(m_run && m_v >= 102 && m_v < 104);
         e_cur.pix = m_re ? pix_of(m_v * 100 + m_h) : 24'h0;
         q_exp.push_back(e_cur);
         n_checks++;
         if (q_exp.size() < 3) begin
            n_fail++;
            $display("FAIL sb_queue got_size=%0d exp_size=3", q_exp.size());
         end else begin
            e_old = q_exp.pop_front();
            if ({de, hsync, vsync, pix_r, pix_g, pix_b} !== e_old) begin
               n_fail++;
               $display("FAIL sb_out got de=%b hs=%b vs=%b pix=%h exp de=%b hs=%b vs=%b pix=%h",
                        de, hsync, vsync, {pix_r, pix_g, pix_b},
                        e_old.de, e_old.hs, e_old.vs, e_old.pix);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Scenario tasks
   // ------------------------------------------------------------------
   task automatic test_reset();
      reset   = 1'b0;
      en      = 1'b1;
      wr_busy = 1'b0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({RE0, de, hsync, vsync, vblank, frame_done, collision} !== 7'b0011100) begin
         n_fail++;
         $display("FAIL reset_ctrl got re/de/hs/vs/vb/fd/col=%b exp=0011100",
                  {RE0, de, hsync, vsync, vblank, frame_done, collision});
      end
      n_checks++;
      if ({pix_r, pix_g, pix_b, Addr0} !== 44'h0) begin
         n_fail++;
         $display("FAIL reset_data got pix=%h addr=%0d exp 0", {pix_r, pix_g, pix_b}, Addr0);
      end
   endtask

   task automatic test_first_frame();
      int hs_low = 0, vs_low = 0, fd_cnt = 0, fd_at = 0, re_cnt = 0;
      int re_late = 0, last_addr = -1, hs_first = 0, mark = 0;
      reset = 1'b1;
      for (int c = 1; c <= 12960; c++) begin
         @(negedge clk);
         if (c == 1) begin
            n_checks++;
            if (RE0 !== 1'b1 || Addr0 !== 20'd0) begin
               n_fail++;
               $display("FAIL first_read got re=%b addr=%0d exp re=1 addr=0", RE0, Addr0);
            end
         end
         if (c == 100) begin
            n_checks++;
            if (Addr0 !== 20'd99) begin
               n_fail++;
               $display("FAIL line0_end got=%0d exp=99", Addr0);
            end
         end
         if (c == 121) begin
            n_checks++;
            if (Addr0 !== 20'd100) begin
               n_fail++;
               $display("FAIL line1_start got=%0d exp=100", Addr0);
            end
         end
         if (hsync === 1'b0) begin
            hs_low++;
            if (hs_first == 0) hs_first = c;
         end
         if (vsync === 1'b0) vs_low++;
         if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_at = c;
         end
         if (RE0 === 1'b1) begin
            re_cnt++;
            last_addr = int'(Addr0);
            if (c > 12000) re_late++;
            if (Addr0 == 20'd257) mark = c;
         end
         if (mark != 0 && c == mark + 2) begin
            n_checks++;
            if ({pix_r, pix_g, pix_b} !== 24'h010100) begin
               n_fail++;
               $display("FAIL pix257 got=%h exp=010100", {pix_r, pix_g, pix_b});
            end
         end
      end
      n_checks++;
      if (mark != 298) begin
         n_fail++;
         $display("FAIL addr257_cycle got=%0d exp=298", mark);
      end
      n_checks++;
      if (hs_first != 107) begin
         n_fail++;
         $display("FAIL hsync_start got=%0d exp=107", hs_first);
      end
      n_checks++;
      if (hs_low != 864 || vs_low != 240) begin
         n_fail++;
         $display("FAIL sync_widths got hs=%0d vs=%0d exp hs=864 vs=240", hs_low, vs_low);
      end
      n_checks++;
      if (fd_cnt != 1 || fd_at != 12960) begin
         n_fail++;
         $display("FAIL frame_period got cnt=%0d at=%0d exp cnt=1 at=12960", fd_cnt, fd_at);
      end
      n_checks++;
      if (re_cnt != 10000 || last_addr != 9999 || re_late != 0) begin
         n_fail++;
         $display("FAIL reads got n=%0d last=%0d late=%0d exp 10000/9999/0",
                  re_cnt, last_addr, re_late);
      end
   endtask

   task automatic test_enable();
      int fd_cnt = 0;
      for (int c = 1; c <= 12960; c++) begin
         @(negedge clk);
         if (c == 1) begin
            n_checks++;
            if (RE0 !== 1'b1 || Addr0 !== 20'd0) begin
               n_fail++;
               $display("FAIL frame2_start got re=%b addr=%0d exp 1/0", RE0, Addr0);
            end
         end
         if (frame_done === 1'b1) fd_cnt++;
         if (c == 6001) en = 1'b0;
      end
      n_checks++;
      if (fd_cnt != 1 || frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL frame2_done got cnt=%0d fd=%b exp 1/1", fd_cnt, frame_done);
      end
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (RE0 !== 1'b0 || vblank !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ctrl i=%0d got re=%b vb=%b exp 0/1", i, RE0, vblank);
         end
         if (i >= 3) begin
            n_checks++;
            if (de !== 1'b0 || hsync !== 1'b1 || {pix_r, pix_g, pix_b} !== 24'h0) begin
               n_fail++;
               $display("FAIL idle_out i=%0d got de=%b hs=%b pix=%h", i, de, hsync,
                        {pix_r, pix_g, pix_b});
            end
         end
         if (i == 5) wr_busy = 1'b1;
         if (i == 6) wr_busy = 1'b0;
      end
      n_checks++;
      if (collision !== 1'b0) begin
         n_fail++;
         $display("FAIL vblank_write got collision=%b exp=0", collision);
      end
      en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (RE0 !== 1'b1 || Addr0 !== 20'd0 || vblank !== 1'b0) begin
         n_fail++;
         $display("FAIL restart got re=%b addr=%0d vb=%b exp 1/0/0", RE0, Addr0, vblank);
      end
   endtask

   task automatic test_collision();
      // Now at cycle 1 of frame 3. Write during hblank (h=104 of line 0).
      repeat (104) @(negedge clk);
      wr_busy = 1'b1;
      @(negedge clk);
      wr_busy = 1'b0;
      n_checks++;
      if (collision !== 1'b0) begin
         n_fail++;
         $display("FAIL hblank_write got collision=%b exp=0", collision);
      end
      // Cycle 106 now; move to an active pixel of line 1.
      repeat (24) @(negedge clk);
      wr_busy = 1'b1;
      @(negedge clk);
      wr_busy = 1'b0;
      n_checks++;
      if (collision !== 1'b1) begin
         n_fail++;
         $display("FAIL active_write got collision=%b exp=1", collision);
      end
      repeat (100) @(negedge clk);
      n_checks++;
      if (collision !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_sticky got=%b exp=1", collision);
      end
   endtask

   task automatic test_reset_midframe();
      repeat (200) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({RE0, vblank, collision, frame_done, de, hsync, vsync} !== 7'b0100011 ||
          Addr0 !== 20'd0 || {pix_r, pix_g, pix_b} !== 24'h0) begin
         n_fail++;
         $display("FAIL midframe_reset got re/vb/col/fd/de/hs/vs=%b addr=%0d pix=%h exp 0100011/0/0",
                  {RE0, vblank, collision, frame_done, de, hsync, vsync}, Addr0,
                  {pix_r, pix_g, pix_b});
      end
      reset = 1'b1;
      for (int c = 1; c <= 130; c++) begin
         @(negedge clk);
         if (c == 1) begin
            n_checks++;
            if (RE0 !== 1'b1 || Addr0 !== 20'd0) begin
               n_fail++;
               $display("FAIL post_reset_start got re=%b addr=%0d exp 1/0", RE0, Addr0);
            end
         end
         if (c == 121) begin
            n_checks++;
            if (Addr0 !== 20'd100) begin
               n_fail++;
               $display("FAIL post_reset_line1 got=%0d exp=100", Addr0);
            end
         end
      end
   endtask

   initial begin
      reset   = 1'b0;
      en      = 1'b0;
      wr_busy = 1'b0;
      test_reset();
      test_first_frame();
      test_enable();
      test_collision();
      test_reset_midframe();
      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
